// File: rtl/dmem_arbiter.sv
// dmem_arbiter: two-requester round-robin arbiter in front of a single-port data memory.
// Each access runs IDLE -> ACCESS -> RESP; illegal size/alignment completes with err=1.
`default_nettype none

module dmem_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req0,
  input  logic                  req1,
  input  logic                  we0,
  input  logic                  we1,
  input  logic [2:0]            funct3_0,
  input  logic [2:0]            funct3_1,
  input  logic [ADDR_WIDTH-1:0] addr0,
  input  logic [ADDR_WIDTH-1:0] addr1,
  input  logic [DATA_WIDTH-1:0] wdata0,
  input  logic [DATA_WIDTH-1:0] wdata1,
  output logic                  gnt0,
  output logic                  gnt1,
  output logic                  rvalid0,
  output logic                  rvalid1,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  err,
  output logic                  mem_wr_en,
  output logic [2:0]            mem_funct3,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wr_data,
  input  logic [DATA_WIDTH-1:0] mem_rd_data
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t                  state_q, state_d;
  logic                    last_grant_q, last_grant_d;
  logic                    id_q, id_d;
  logic                    we_q, we_d;
  logic [2:0]              funct3_q, funct3_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
  logic                    err_q, err_d;
  logic                    rvalid0_q, rvalid0_d;
  logic                    rvalid1_q, rvalid1_d;
  logic                    pick1;
  logic                    size_ok;
  logic                    align_ok;
  logic                    legal;
  logic                    in_access;

  // lbu (100) is load-only; word accesses must be naturally aligned.
  always_comb begin
    if (we_q) size_ok = (funct3_q == 3'b000) || (funct3_q == 3'b010);
    else      size_ok = (funct3_q == 3'b000) || (funct3_q == 3'b010) || (funct3_q == 3'b100);
    align_ok = !((funct3_q == 3'b010) && (addr_q[1:0] != 2'b00));
    legal    = size_ok && align_ok;
  end

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    id_d         = id_q;
    we_d         = we_q;
    funct3_d     = funct3_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    rdata_d      = rdata_q;
    err_d        = err_q;
    rvalid0_d    = 1'b0;
    rvalid1_d    = 1'b0;
    gnt0         = 1'b0;
    gnt1         = 1'b0;
    // Requester 1 wins a tie only when requester 0 was granted last.
    pick1        = req1 && (!req0 || !last_grant_q);
    case (state_q)
      IDLE: begin
        if (req0 || req1) begin
          gnt0         = !pick1;
          gnt1         = pick1;
          id_d         = pick1;
          last_grant_d = pick1;
          we_d         = pick1 ? we1      : we0;
          funct3_d     = pick1 ? funct3_1 : funct3_0;
          addr_d       = pick1 ? addr1    : addr0;
          wdata_d      = pick1 ? wdata1   : wdata0;
          state_d      = ACCESS;
        end
      end
      ACCESS: begin
        rdata_d   = (legal && !we_q) ? mem_rd_data : '0;
        err_d     = !legal;
        rvalid0_d = !id_q;
        rvalid1_d = id_q;
        state_d   = RESP;
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      id_q         <= 1'b0;
      we_q         <= 1'b0;
      funct3_q     <= 3'b000;
      addr_q       <= '0;
      wdata_q      <= '0;
      rdata_q      <= '0;
      err_q        <= 1'b0;
      rvalid0_q    <= 1'b0;
      rvalid1_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      id_q         <= id_d;
      we_q         <= we_d;
      funct3_q     <= funct3_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      rdata_q      <= rdata_d;
      err_q        <= err_d;
      rvalid0_q    <= rvalid0_d;
      rvalid1_q    <= rvalid1_d;
    end
  end

  // Memory port is decoded from the state flop so an async reset silences it at once.
  assign in_access   = (state_q == ACCESS);
  assign mem_wr_en   = in_access && we_q && legal;
  assign mem_funct3  = in_access ? funct3_q : 3'b000;
  assign mem_addr    = in_access ? addr_q   : '0;
  assign mem_wr_data = in_access ? wdata_q  : '0;
  assign rdata       = rdata_q;
  assign err         = err_q;
  assign rvalid0     = rvalid0_q;
  assign rvalid1     = rvalid1_q;

endmodule

`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed vector table, hand-written corner sequences and random traffic,
// all checked against a transaction-level model keyed on cycles since grant.
`default_nettype none

module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req0, req1, we0, we1;
  logic [2:0]  funct3_0, funct3_1;
  logic [31:0] addr0, addr1, wdata0, wdata1, mem_rd_data;
  logic        gnt0, gnt1, rvalid0, rvalid1, err, mem_wr_en;
  logic [31:0] rdata, mem_addr, mem_wr_data;
  logic [2:0]  mem_funct3;

  dmem_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .funct3_0(funct3_0), .funct3_1(funct3_1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
    .rdata(rdata), .err(err), .mem_wr_en(mem_wr_en), .mem_funct3(mem_funct3),
    .mem_addr(mem_addr), .mem_wr_data(mem_wr_data), .mem_rd_data(mem_rd_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        req0, req1, we0, we1;
    logic [2:0]  f0, f1;
    logic [31:0] a0, a1, w0, w1, rd;
    bit          has_exp;
    logic        g0, g1, r0, r1, wen, err;
  } vec_t;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  // Transaction-level model: one outstanding access, behaviour keyed on cycles since its grant.
  bit          m_busy, m_id, m_we, m_legal, m_err, m_last;
  int          m_g;
  logic [2:0]  m_f3;
  logic [31:0] m_addr, m_wdata, m_rdata;

  task automatic chk1(input string name, input logic act, input logic exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0b expected %0b (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %08h expected %08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic bit legal_f(input bit we, input logic [2:0] f3, input logic [31:0] a);
    bit size_ok;
    if (we) size_ok = f3 inside {3'b000, 3'b010};
    else    size_ok = f3 inside {3'b000, 3'b010, 3'b100};
    if (f3 == 3'b010 && a[1:0] != 2'b00) return 1'b0;
    return size_ok;
  endfunction

  function automatic vec_t mk(input logic r0, input logic w_0, input logic [2:0] f0,
                              input logic [31:0] a0, input logic [31:0] d0,
                              input logic r1, input logic w_1, input logic [2:0] f1,
                              input logic [31:0] a1, input logic [31:0] d1, input logic [31:0] rd);
    vec_t v;
    v.req0 = r0; v.we0 = w_0; v.f0 = f0; v.a0 = a0; v.w0 = d0;
    v.req1 = r1; v.we1 = w_1; v.f1 = f1; v.a1 = a1; v.w1 = d1;
    v.rd = rd; v.has_exp = 1'b0;
    v.g0 = 0; v.g1 = 0; v.r0 = 0; v.r1 = 0; v.wen = 0; v.err = 0;
    return v;
  endfunction

  function automatic vec_t ex(input vec_t b, input logic g0, input logic g1, input logic r0,
                              input logic r1, input logic wen, input logic e);
    vec_t v = b;
    v.has_exp = 1'b1;
    v.g0 = g0; v.g1 = g1; v.r0 = r0; v.r1 = r1; v.wen = wen; v.err = e;
    return v;
  endfunction

  function automatic vec_t nop(input logic [31:0] rd);
    return mk(0, 0, 3'b000, 0, 0, 0, 0, 3'b000, 0, 0, rd);
  endfunction

  task automatic model_reset();
    m_busy = 0; m_last = 1; m_rdata = 0; m_err = 0; m_g = 0;
  endtask

  task automatic step(input vec_t v);
    int   age;
    bit   eg0, eg1, acc;
    @(negedge clk);
    req0 = v.req0; we0 = v.we0; funct3_0 = v.f0; addr0 = v.a0; wdata0 = v.w0;
    req1 = v.req1; we1 = v.we1; funct3_1 = v.f1; addr1 = v.a1; wdata1 = v.w1;
    mem_rd_data = v.rd;
    #1;
    age = cyc - m_g;
    if (m_busy && age >= 3) m_busy = 0;
    eg0 = 0; eg1 = 0;
    if (!m_busy) begin
      if (v.req0 && v.req1) begin eg0 = m_last; eg1 = !m_last; end
      else begin eg0 = v.req0; eg1 = v.req1; end
    end
    acc = m_busy && age == 1;
    chk1("gnt0", gnt0, eg0);
    chk1("gnt1", gnt1, eg1);
    chk1("rvalid0", rvalid0, m_busy && age == 2 && !m_id);
    chk1("rvalid1", rvalid1, m_busy && age == 2 && m_id);
    chk1("mem_wr_en", mem_wr_en, acc && m_we && m_legal);
    chk32("mem_funct3", {29'b0, mem_funct3}, acc ? {29'b0, m_f3} : 32'h0);
    chk32("mem_addr", mem_addr, acc ? m_addr : 32'h0);
    chk32("mem_wr_data", mem_wr_data, acc ? m_wdata : 32'h0);
    chk32("rdata", rdata, m_rdata);
    chk1("err", err, m_err);
    if (v.has_exp) begin
      chk1("tbl_gnt0", gnt0, v.g0);
      chk1("tbl_gnt1", gnt1, v.g1);
      chk1("tbl_rvalid0", rvalid0, v.r0);
      chk1("tbl_rvalid1", rvalid1, v.r1);
      chk1("tbl_mem_wr_en", mem_wr_en, v.wen);
      chk1("tbl_err", err, v.err);
    end
    if (acc) begin
      m_rdata = (m_legal && !m_we) ? v.rd : 32'h0;
      m_err   = !m_legal;
    end
    if (eg0 || eg1) begin
      m_busy  = 1; m_g = cyc; m_id = eg1; m_last = eg1;
      m_we    = eg1 ? v.we1 : v.we0;
      m_f3    = eg1 ? v.f1 : v.f0;
      m_addr  = eg1 ? v.a1 : v.a0;
      m_wdata = eg1 ? v.w1 : v.w0;
      m_legal = legal_f(m_we, m_f3, m_addr);
    end
    cyc++;
  endtask

  // Asserts reset between edges and checks that everything clears without waiting for a clock.
  task automatic do_reset();
    req0 = 0; req1 = 0;
    rst_n = 1'b0;
    #1;
    chk1("rst_gnt0", gnt0, 1'b0);
    chk1("rst_gnt1", gnt1, 1'b0);
    chk1("rst_rvalid0", rvalid0, 1'b0);
    chk1("rst_rvalid1", rvalid1, 1'b0);
    chk1("rst_err", err, 1'b0);
    chk1("rst_mem_wr_en", mem_wr_en, 1'b0);
    chk32("rst_rdata", rdata, 32'h0);
    chk32("rst_mem_addr", mem_addr, 32'h0);
    chk32("rst_mem_wr_data", mem_wr_data, 32'h0);
    chk32("rst_mem_funct3", {29'b0, mem_funct3}, 32'h0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  vec_t tbl[12];
  int   gorder[$];

  initial begin
    vec_t rv;
    req0 = 0; req1 = 0; we0 = 0; we1 = 0; funct3_0 = 0; funct3_1 = 0;
    addr0 = 0; addr1 = 0; wdata0 = 0; wdata1 = 0; mem_rd_data = 0;
    model_reset();
    repeat (2) @(negedge clk);
    do_reset();

    // sw ok, misaligned sw, store with lbu code, lb returning a pre-extended byte
    tbl[0]  = ex(mk(1, 1, 3'b010, 32'h8, 32'hDEADBEEF, 0, 0, 3'b000, 0, 0, 32'h0), 1, 0, 0, 0, 0, 0);
    tbl[1]  = ex(nop(32'h1111_2222),                                              0, 0, 0, 0, 1, 0);
    tbl[2]  = ex(nop(32'h0),                                                      0, 0, 1, 0, 0, 0);
    tbl[3]  = ex(mk(1, 1, 3'b010, 32'h6, 32'h1234, 0, 0, 3'b000, 0, 0, 32'h0),    1, 0, 0, 0, 0, 0);
    tbl[4]  = ex(nop(32'hAAAA_5555),                                              0, 0, 0, 0, 0, 0);
    tbl[5]  = ex(nop(32'h0),                                                      0, 0, 1, 0, 0, 1);
    tbl[6]  = ex(mk(0, 0, 3'b000, 0, 0, 1, 1, 3'b100, 32'h10, 32'h55, 32'h0),     0, 1, 0, 0, 0, 1);
    tbl[7]  = ex(nop(32'h7777_7777),                                              0, 0, 0, 0, 0, 1);
    tbl[8]  = ex(nop(32'h0),                                                      0, 0, 0, 1, 0, 1);
    tbl[9]  = ex(mk(0, 0, 3'b000, 0, 0, 1, 0, 3'b000, 32'h9, 0, 32'h0),           0, 1, 0, 0, 0, 1);
    tbl[10] = ex(nop(32'hFFFFFFBE),                                               0, 0, 0, 0, 0, 1);
    tbl[11] = ex(nop(32'h0),                                                      0, 0, 0, 1, 0, 0);
    for (int i = 0; i < 12; i++) step(tbl[i]);
    chk32("lb_rdata", rdata, 32'hFFFFFFBE);

    // Both requesters hold lw 0x8: grants must alternate starting with requester 0.
    for (int i = 0; i < 12; i++) begin
      step(mk(1, 0, 3'b010, 32'h8, 0, 1, 0, 3'b010, 32'h8, 0, 32'hDEADBEEF));
      if (gnt0) gorder.push_back(0);
      if (gnt1) gorder.push_back(1);
    end
    chk32("rr_grant_count", gorder.size(), 32'd4);
    for (int i = 0; i < gorder.size(); i++) chk32("rr_grant_order", gorder[i], i % 2);
    step(nop(32'h0));
    step(nop(32'h0));
    chk32("rr_rdata", rdata, 32'hDEADBEEF);

    // Reset in the ACCESS cycle of a store: write aborted, no response, tie goes to requester 0.
    step(mk(0, 0, 3'b000, 0, 0, 1, 1, 3'b010, 32'h20, 32'hCAFE0001, 32'h0));
    step(nop(32'h0));
    chk1("pre_reset_wr_en", mem_wr_en, 1'b1);
    do_reset();
    for (int i = 0; i < 3; i++) step(nop(32'h0));
    step(mk(1, 0, 3'b000, 32'h3, 0, 1, 0, 3'b100, 32'h5, 0, 32'h0));
    chk1("tie_after_reset_gnt0", gnt0, 1'b1);
    for (int i = 0; i < 3; i++) step(nop($urandom));

    for (int i = 0; i < 600; i++) begin
      logic [2:0] fa, fb;
      fa = 3'($urandom); fb = 3'($urandom);
      if ($urandom_range(0, 1) == 0) fa = fa & 3'b110;
      if ($urandom_range(0, 1) == 0) fb = fb & 3'b110;
      rv = mk(1'($urandom), 1'($urandom), fa, $urandom & 32'h0000_03FF, $urandom,
              1'($urandom), 1'($urandom), fb, $urandom,               $urandom, $urandom);
      step(rv);
      if ($urandom_range(0, 59) == 0) do_reset();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
